// File: rtl/seq_alu_pkg.sv
// Shared types for seq_alu: operation codes and control states.
package seq_alu_pkg;

    typedef enum logic [3:0] {
        OP_ADD  = 4'd0,
        OP_SUB  = 4'd1,
        OP_MUL  = 4'd2,
        OP_DIV  = 4'd3,
        OP_SHR  = 4'd4,
        OP_SHRA = 4'd5,
        OP_SHL  = 4'd6,
        OP_ROR  = 4'd7,
        OP_ROL  = 4'd8,
        OP_AND  = 4'd9,
        OP_OR   = 4'd10,
        OP_NEG  = 4'd11,
        OP_NOT  = 4'd12
    } op_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        MUL     = 2'd1,
        DIV     = 2'd2,
        DIV_FIX = 2'd3
    } state_t;

endpackage

// File: rtl/seq_alu_muldiv.sv
// Iterative signed multiply (radix-2 Booth) and divide (non-restoring) datapath.
// Compiled only when SEQ_ALU_MULDIV_EN is defined.
`ifdef SEQ_ALU_MULDIV_EN
module seq_alu_muldiv
    import seq_alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_mul,
    input  logic             load_div,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             last,
    output logic [WIDTH-1:0] mul_hi,
    output logic [WIDTH-1:0] mul_lo,
    output logic [WIDTH-1:0] div_q,
    output logic [WIDTH-1:0] div_r
);

    localparam int AW = WIDTH + 2;
    localparam logic [SHW:0] CNT_LOAD = (SHW+1)'(WIDTH - 1);

    // acc is the Booth partial product or the non-restoring partial remainder;
    // two guard bits keep 2R+bit and A+-M from overflowing.
    logic signed [AW-1:0] acc, acc_d, booth_sum, div_shift, div_next, m_ext, d_ext;
    logic [WIDTH-1:0]     qreg, qreg_d, opnd, r_fix;
    logic                 q_m1, neg_q, neg_r, is_div, run;
    logic [SHW:0]         cnt;

    assign m_ext = {{2{opnd[WIDTH-1]}}, opnd};
    assign d_ext = {2'b00, opnd};
    assign last  = run && (cnt == '0);

    always_comb begin
        booth_sum = acc;
        case ({qreg[0], q_m1})
            2'b01:   booth_sum = acc + m_ext;
            2'b10:   booth_sum = acc - m_ext;
            default: booth_sum = acc;
        endcase
        div_shift = {acc[WIDTH:0], qreg[WIDTH-1]};
        div_next  = acc[AW-1] ? (div_shift + d_ext) : (div_shift - d_ext);
        if (is_div) begin
            acc_d  = div_next;
            qreg_d = {qreg[WIDTH-2:0], ~div_next[AW-1]};
        end else begin
            acc_d  = booth_sum >>> 1;
            qreg_d = {booth_sum[0], qreg[WIDTH-1:1]};
        end
    end

    assign mul_hi = acc_d[WIDTH-1:0];
    assign mul_lo = qreg_d;

    // Remainder correction and sign fix-up, consumed in DIV_FIX.
    assign r_fix = acc[AW-1] ? (acc[WIDTH-1:0] + opnd) : acc[WIDTH-1:0];
    assign div_q = neg_q ? -qreg : qreg;
    assign div_r = neg_r ? -r_fix : r_fix;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            run    <= 1'b0;
            cnt    <= '0;
            is_div <= 1'b0;
        end else if (load_mul || load_div) begin
            run    <= 1'b1;
            cnt    <= CNT_LOAD;
            is_div <= load_div;
        end else if (run) begin
            if (cnt == '0) run <= 1'b0;
            else           cnt <= cnt - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (load_mul) begin
            acc  <= '0;
            qreg <= b;
            q_m1 <= 1'b0;
            opnd <= a;
        end else if (load_div) begin
            acc   <= '0;
            qreg  <= a[WIDTH-1] ? -a : a;
            opnd  <= b[WIDTH-1] ? -b : b;
            neg_q <= a[WIDTH-1] ^ b[WIDTH-1];
            neg_r <= a[WIDTH-1];
        end else if (run) begin
            acc  <= acc_d;
            qreg <= qreg_d;
            q_m1 <= qreg[0];
        end
    end

endmodule
`endif

// File: rtl/seq_alu.sv
// Multi-cycle ALU: single-cycle ops, handshake FSM and result registers.
// Define SEQ_ALU_MULDIV_EN to build the iterative MUL/DIV path.
module seq_alu
    import seq_alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  op_t              op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] zhigh,
    output logic [WIDTH-1:0] zlo,
    output logic             div_by_zero
);

    localparam logic [WIDTH-1:0] WIDTH_V = WIDTH'(WIDTH);

    state_t           state, state_d;
    logic             busy_d, done_d, dbz_d;
    logic [WIDTH-1:0] zhigh_d, zlo_d;

    function automatic logic [WIDTH-1:0] single_op(input op_t f, input logic [WIDTH-1:0] x,
                                                   input logic [WIDTH-1:0] y);
        logic             big;
        logic [SHW-1:0]   sh;
        logic [2*WIDTH-1:0] dbl;
        big = (y >= WIDTH_V);
        sh  = y[SHW-1:0];
        dbl = {x, x};
        case (f)
            OP_ADD:  single_op = x + y;
            OP_SUB:  single_op = x - y;
            OP_SHR:  single_op = big ? '0 : (x >> sh);
            OP_SHRA: single_op = big ? {WIDTH{x[WIDTH-1]}} : ($signed(x) >>> sh);
            OP_SHL:  single_op = big ? '0 : (x << sh);
            OP_ROR: begin
                dbl       = dbl >> sh;
                single_op = dbl[WIDTH-1:0];
            end
            OP_ROL: begin
                dbl       = dbl << sh;
                single_op = dbl[2*WIDTH-1:WIDTH];
            end
            OP_AND:  single_op = x & y;
            OP_OR:   single_op = x | y;
            OP_NEG:  single_op = -y;
            OP_NOT:  single_op = ~y;
            default: single_op = '0;
        endcase
    endfunction

`ifdef SEQ_ALU_MULDIV_EN
    logic             load_mul, load_div, md_last;
    logic [WIDTH-1:0] mul_hi, mul_lo, div_q, div_r;

    assign load_mul = start && !busy && (op == OP_MUL);
    assign load_div = start && !busy && (op == OP_DIV) && (b != '0);

    seq_alu_muldiv #(.WIDTH(WIDTH), .SHW(SHW)) u_muldiv (
        .clk      (clk),
        .reset    (reset),
        .load_mul (load_mul),
        .load_div (load_div),
        .a        (a),
        .b        (b),
        .last     (md_last),
        .mul_hi   (mul_hi),
        .mul_lo   (mul_lo),
        .div_q    (div_q),
        .div_r    (div_r)
    );
`endif

    always_comb begin
        state_d = state;
        busy_d  = busy;
        done_d  = 1'b0;
        zhigh_d = zhigh;
        zlo_d   = zlo;
        dbz_d   = div_by_zero;
        case (state)
            IDLE: begin
                if (start) begin
                    dbz_d = 1'b0;
`ifdef SEQ_ALU_MULDIV_EN
                    if (load_mul) begin
                        state_d = MUL;
                        busy_d  = 1'b1;
                    end else if (load_div) begin
                        state_d = DIV;
                        busy_d  = 1'b1;
                    end else if (op == OP_DIV) begin
                        zhigh_d = a;
                        zlo_d   = '1;
                        dbz_d   = 1'b1;
                        done_d  = 1'b1;
                    end else
`endif
                    begin
                        zhigh_d = '0;
                        zlo_d   = single_op(op, a, b);
                        done_d  = 1'b1;
                    end
                end
            end
`ifdef SEQ_ALU_MULDIV_EN
            MUL: begin
                if (md_last) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    zhigh_d = mul_hi;
                    zlo_d   = mul_lo;
                end
            end
            DIV: begin
                if (md_last) state_d = DIV_FIX;
            end
            DIV_FIX: begin
                state_d = IDLE;
                busy_d  = 1'b0;
                done_d  = 1'b1;
                zhigh_d = div_r;
                zlo_d   = div_q;
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            busy        <= 1'b0;
            done        <= 1'b0;
            zhigh       <= '0;
            zlo         <= '0;
            div_by_zero <= 1'b0;
        end else begin
            state       <= state_d;
            busy        <= busy_d;
            done        <= done_d;
            zhigh       <= zhigh_d;
            zlo         <= zlo_d;
            div_by_zero <= dbz_d;
        end
    end

endmodule

// File: tb/tb_seq_alu.sv
// Self-checking bench for seq_alu with a behavioural reference model.
// Expectations follow SEQ_ALU_MULDIV_EN the same way the design does.
module tb_seq_alu;
    import seq_alu_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    op_t         op_s;
    logic [31:0] a_s, b_s;
    logic        busy, done, div_by_zero;
    logic [31:0] zhigh, zlo;

    int checks   = 0;
    int failures = 0;

    seq_alu #(.WIDTH(32)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .op          (op_s),
        .a           (a_s),
        .b           (b_s),
        .busy        (busy),
        .done        (done),
        .zhigh       (zhigh),
        .zlo         (zlo),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: results straight from the arithmetic definitions, 64-bit math.
    function automatic void model(input logic [3:0] opc, input logic [31:0] x, input logic [31:0] y,
                                  output logic [31:0] hi, output logic [31:0] lo,
                                  output logic dz, output int lat);
        longint sx, sy, p, q, r;
        int     amt;
        sx  = longint'($signed(x));
        sy  = longint'($signed(y));
        amt = int'(y % 32);
        hi  = 32'h0;
        lo  = 32'h0;
        dz  = 1'b0;
        lat = 1;
        case (op_t'(opc))
            OP_ADD:  lo = x + y;
            OP_SUB:  lo = x - y;
            OP_AND:  lo = x & y;
            OP_OR:   lo = x | y;
            OP_NEG:  lo = 32'h0 - y;
            OP_NOT:  lo = ~y;
            OP_SHR:  lo = (y >= 32) ? 32'h0 : (x >> y);
            OP_SHL:  lo = (y >= 32) ? 32'h0 : (x << y);
            OP_SHRA: begin
                p  = sx >>> ((y >= 32) ? 32'd31 : y);
                lo = p[31:0];
            end
            OP_ROR:  lo = (x >> amt) | (x << (32 - amt));
            OP_ROL:  lo = (x << amt) | (x >> (32 - amt));
`ifdef SEQ_ALU_MULDIV_EN
            OP_MUL: begin
                p   = sx * sy;
                hi  = p[63:32];
                lo  = p[31:0];
                lat = 33;
            end
            OP_DIV: begin
                if (y == 32'h0) begin
                    lo = 32'hFFFF_FFFF;
                    hi = x;
                    dz = 1'b1;
                end else begin
                    q   = sx / sy;
                    r   = sx % sy;
                    lo  = q[31:0];
                    hi  = r[31:0];
                    lat = 34;
                end
            end
`endif
            default: lo = 32'h0;
        endcase
    endfunction

    task automatic do_op(input string tag, input logic [3:0] opc, input logic [31:0] x,
                         input logic [31:0] y, input int poke);
        logic [31:0] eh, el;
        logic        ed;
        int          elat, cyc;
        bit          got;
        model(opc, x, y, eh, el, ed, elat);
        @(negedge clk);
        start = 1'b1;
        op_s  = op_t'(opc);
        a_s   = x;
        b_s   = y;
        @(posedge clk);
        #1;
        start = 1'b0;
        op_s  = OP_ADD;
        a_s   = $urandom;
        b_s   = $urandom;
        cyc   = 0;
        got   = 1'b0;
        while (!got && cyc < 80) begin
            @(negedge clk);
            cyc++;
            if (done) got = 1'b1;
            else begin
                if (cyc == 2 && elat > 2) check({tag, "_busy_mid"}, 64'(busy), 64'd1);
                start = (cyc == poke);
            end
        end
        start = 1'b0;
        check({tag, "_lat"}, 64'(cyc), 64'(elat));
        check({tag, "_hi"}, 64'(zhigh), 64'(eh));
        check({tag, "_lo"}, 64'(zlo), 64'(el));
        check({tag, "_dbz"}, 64'(div_by_zero), 64'(ed));
        check({tag, "_busy_done"}, 64'(busy), 64'd0);
        @(negedge clk);
        check({tag, "_pulse"}, 64'(done), 64'd0);
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        op_s  = OP_ADD;
        a_s   = 32'h0;
        b_s   = 32'h0;
        repeat (3) @(negedge clk);
        check("rst_done", 64'(done), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_zlo", 64'(zlo), 64'd0);
        check("rst_zhigh", 64'(zhigh), 64'd0);
        check("rst_dbz", 64'(div_by_zero), 64'd0);
        reset = 1'b0;

        // Back-to-back single-cycle ops: ADD then SUB on consecutive edges.
        @(negedge clk);
        start = 1'b1;
        op_s  = OP_ADD;
        a_s   = 32'hFFFF_FFFF;
        b_s   = 32'h1;
        @(posedge clk);
        #1;
        op_s = OP_SUB;
        a_s  = 32'd5;
        b_s  = 32'd7;
        @(negedge clk);
        check("b2b_add_done", 64'(done), 64'd1);
        check("b2b_add_lo", 64'(zlo), 64'd0);
        check("b2b_add_hi", 64'(zhigh), 64'd0);
        @(posedge clk);
        #1;
        start = 1'b0;
        @(negedge clk);
        check("b2b_sub_done", 64'(done), 64'd1);
        check("b2b_sub_lo", 64'(zlo), 64'hFFFF_FFFE);
        @(negedge clk);
        check("b2b_pulse", 64'(done), 64'd0);

        do_op("shra40", OP_SHRA, 32'h8000_0000, 32'd40, 0);
        do_op("rol33", OP_ROL, 32'h8000_0001, 32'd33, 0);
        do_op("mul_m3x7", OP_MUL, -32'sd3, 32'd7, 10);
        do_op("mul_min", OP_MUL, 32'h8000_0000, 32'h8000_0000, 0);
        do_op("mul_3x4", OP_MUL, 32'd3, 32'd4, 0);
        do_op("div_m7d2", OP_DIV, -32'sd7, 32'd2, 0);
        do_op("div_by0", OP_DIV, 32'd5, 32'd0, 0);
        do_op("div_min", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 0);
        do_op("illegal13", 4'd13, 32'h1234_5678, 32'h9ABC_DEF0, 0);

        // Reset in the middle of a DIV discards everything immediately.
        do_op("or_pre", OP_OR, 32'h00F0_0F00, 32'h1234_0001, 0);
        @(negedge clk);
        start = 1'b1;
        op_s  = OP_DIV;
        a_s   = -32'sd100;
        b_s   = 32'd7;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (12) @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        check("midrst_zlo", 64'(zlo), 64'd0);
        check("midrst_zhigh", 64'(zhigh), 64'd0);
        check("midrst_busy", 64'(busy), 64'd0);
        check("midrst_done", 64'(done), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        do_op("add_2p2", OP_ADD, 32'd2, 32'd2, 0);

        for (int i = 0; i < 40; i++) begin
            logic [3:0]  opc;
            logic [31:0] x, y;
            opc = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 2) == 0) opc = 4'($urandom_range(2, 3));
            x = $urandom;
            y = $urandom;
            case ($urandom_range(0, 3))
                0: y = 32'($urandom_range(0, 40));
                1: if (opc == 4'd3) y = 32'h0;
                default: ;
            endcase
            do_op($sformatf("rnd%0d", i), opc, x, y, 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
